// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input FIFOs, the switch allocator and the crossbar.
interface switch_allocator_if;
  logic [4:0]  req_valid;
  logic [14:0] req_dst;
  logic [4:0]  req_tail;
  logic [4:0]  out_ready;
  logic [2:0]  S_E;
  logic [2:0]  S_W;
  logic [2:0]  S_N;
  logic [2:0]  S_S;
  logic [2:0]  S_eject;
  logic [4:0]  pop;

  modport master (
    output req_valid, req_dst, req_tail, out_ready,
    input  S_E, S_W, S_N, S_S, S_eject, pop
  );

  modport slave (
    input  req_valid, req_dst, req_tail, out_ready,
    output S_E, S_W, S_N, S_S, S_eject, pop
  );
endinterface

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output round-robin grant, held from head flit to tail flit.
module switch_allocator #(
  parameter int unsigned NPORTS   = 5,
  parameter logic [2:0]  IDLE_SEL = 3'b111
) (
  input logic               clk,
  input logic               reset,
  switch_allocator_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_LOCKED} st_e;

  st_e               r_st    [NPORTS];
  logic [2:0]        r_owner [NPORTS];
  logic [2:0]        r_rr    [NPORTS];

  st_e               w_st_nxt    [NPORTS];
  logic [2:0]        w_owner_nxt [NPORTS];
  logic [2:0]        w_rr_nxt    [NPORTS];
  logic [3:0]        w_pick      [NPORTS];
  logic [2:0]        w_sel       [NPORTS];
  logic [NPORTS-1:0] w_cand      [NPORTS];
  logic [NPORTS-1:0] w_owns;
  logic [NPORTS-1:0] w_xfer;
  logic [NPORTS-1:0] w_own_tail;
  logic [NPORTS-1:0] w_pop;

  // Cyclic first-hit search from ptr; returns {found, winner}.
  function automatic logic [3:0] rr_pick(input logic [2:0] ptr, input logic [NPORTS-1:0] cand);
    logic       hit;
    logic [2:0] win;
    logic [3:0] idx;
    hit = 1'b0;
    win = 3'd0;
    for (int k = 0; k < NPORTS; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(NPORTS)) idx = idx - 4'(NPORTS);
      if (!hit && cand[idx[2:0]]) begin
        hit = 1'b1;
        win = idx[2:0];
      end
    end
    return {hit, win};
  endfunction

  // Owner decode: selects, transfers and pops of locked outputs.
  always_comb begin
    w_owns     = '0;
    w_xfer     = '0;
    w_own_tail = '0;
    w_pop      = '0;
    for (int o = 0; o < NPORTS; o++) begin
      w_sel[o] = (r_st[o] == ST_LOCKED) ? r_owner[o] : IDLE_SEL;
      for (int i = 0; i < NPORTS; i++) begin
        if (r_st[o] == ST_LOCKED && r_owner[o] == 3'(i)) begin
          w_owns[i]     = 1'b1;
          w_own_tail[o] = bus.req_tail[i];
          if (bus.req_valid[i] && bus.req_dst[3*i +: 3] == 3'(o) && bus.out_ready[o]) begin
            w_xfer[o] = 1'b1;
            w_pop[i]  = 1'b1;
          end
        end
      end
    end
  end

  // Inputs holding a lock elsewhere are excluded from new arbitration.
  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      w_cand[o] = '0;
      for (int i = 0; i < NPORTS; i++) begin
        w_cand[o][i] = bus.req_valid[i] && (bus.req_dst[3*i +: 3] == 3'(o)) && !w_owns[i];
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      w_st_nxt[o]    = r_st[o];
      w_owner_nxt[o] = r_owner[o];
      w_rr_nxt[o]    = r_rr[o];
      w_pick[o]      = rr_pick(r_rr[o], w_cand[o]);
      case (r_st[o])
        ST_IDLE: begin
          if (w_pick[o][3]) begin
            w_st_nxt[o]    = ST_LOCKED;
            w_owner_nxt[o] = w_pick[o][2:0];
          end
        end
        ST_LOCKED: begin
          if (w_xfer[o] && w_own_tail[o]) begin
            w_st_nxt[o] = ST_IDLE;
            w_rr_nxt[o] = (r_owner[o] == 3'(NPORTS - 1)) ? 3'd0 : r_owner[o] + 3'd1;
          end
        end
        default: w_st_nxt[o] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int o = 0; o < NPORTS; o++) begin
      if (reset) begin
        r_st[o]    <= ST_IDLE;
        r_owner[o] <= 3'd0;
        r_rr[o]    <= 3'd0;
      end else begin
        r_st[o]    <= w_st_nxt[o];
        r_owner[o] <= w_owner_nxt[o];
        r_rr[o]    <= w_rr_nxt[o];
      end
    end
  end

  assign bus.S_E     = w_sel[0];
  assign bus.S_W     = w_sel[1];
  assign bus.S_N     = w_sel[2];
  assign bus.S_S     = w_sel[3];
  assign bus.S_eject = w_sel[4];
  assign bus.pop     = w_pop;

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-router wormhole switch allocator.
- Arbitrates five input ports (E, W, N, S, local inject) for five output ports (E, W, N, S, eject).
- Drives the crossbar select codes S_E/S_W/S_N/S_S/S_eject and the per-input FIFO pop strobes.
- Pop strobes also feed the router's output-enable logic as e/w/n/s/j push signals.
- Round-robin per output port; each grant is locked from head flit through tail flit.

Parameters:
- NPORTS, 5, number of input/output ports; only 5 is supported, encoding fixed.
- IDLE_SEL, 3'b111, select code driven by an output that has no owner.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- req_valid  input  5  flit present at head of input FIFO i. Bit order 0=E, 1=W, 2=N, 3=S, 4=local.
- req_dst  input  15  requested output for input i, in bits [3i+2:3i]. Codes: 0=E, 1=W, 2=N, 3=S, 4=eject.
- req_tail  input  5  head flit of input i is a tail flit; a single-flit packet has tail=1 on its only flit.
- out_ready  input  5  downstream of output o can accept a flit this cycle.
- S_E, S_W, S_N, S_S, S_eject  output  3 each  crossbar source select for each output: input code 0..4, or IDLE_SEL.
- pop  output  5  input i's flit crosses the crossbar this cycle; dequeue it.

Behaviour:
- State per output o:
  - st[o] in {IDLE, LOCKED};
  - owner[o], 3 bits;
  - rr_ptr[o], 3 bits, range 0..4.
- Reset (synchronous, clocked):
  - all st=IDLE, owner=0, rr_ptr=0;
  - all selects = IDLE_SEL, pop = 0, effective the cycle after reset is sampled high;
  - a reset mid-packet drops every lock; no partial-packet recovery.
- Candidates for output o: inputs i with req_valid[i]=1 and req_dst[i]==o.
  - req_dst values 5..7 are never candidates for any output.
  - An input that currently owns any output is not a candidate elsewhere.
- IDLE arbitration:
  - Scan candidates cyclically starting at rr_ptr[o]; the first hit wins.
  - Next cycle: st[o]=LOCKED, owner[o]=winner.
  - No candidates: stay IDLE.
  - Arbitration does not depend on out_ready.
- Select outputs are combinational from registered state: select(o) = owner[o] when LOCKED, else IDLE_SEL.
- Transfer on output o in a cycle when all hold: st[o]=LOCKED, req_valid[owner]=1, req_dst[owner]==o, out_ready[o]=1.
  - pop[owner]=1 that cycle, combinational.
  - pop is never asserted for more than one output per input; at most one pop per input per cycle.
- Tail handling: a transfer with req_tail[owner]=1 causes, next cycle, st[o]=IDLE and rr_ptr[o]=(owner+1) mod 5 (4 wraps to 0).
- Back-pressure:
  - out_ready=0 while LOCKED: select held, pop=0, lock kept indefinitely.
  - req_valid[owner]=0 mid-packet (bubble): lock kept, no pop.
- Latency:
  - Head flit valid in cycle t with output IDLE → LOCKED in t+1; first pop earliest in t+1.
  - Steady state: one flit per cycle per output.
  - After a tail transfer in cycle t, the output is IDLE in t+1 and re-arbitrates.
  - A next packet's first pop is earliest in t+2, i.e. a 1-cycle bubble per packet boundary.
- Simultaneous events:
  - All five outputs arbitrate independently in the same cycle.
  - Two outputs cannot choose the same input, since each input presents one req_dst.
  - A tail transfer and a new request arriving in the same cycle: the new request is considered in the following cycle.
- Sender contract: req_dst for an input is stable from head to tail. A change while locked is treated as a stall (no pop) until it matches again.

Test Plan:
- Reset, then idle: reset=1 for 2 cycles → all selects 3'b111, pop=5'b0; with no requests they stay so.
- Single-flit request: req_valid=5'b00001, req_dst[2:0]=3 (E→S), tail=1, out_ready all 1.
  - Cycle t+1: S_S=3'b000, pop=5'b00001.
  - Cycle t+2: S_S=3'b111, rr_ptr[S]=1.
- Round-robin contention: inputs W, N, local all target eject with continuous single-flit packets.
  - Grant order W(1), N(2), local(4), W(1), …
  - S_eject sequence 1, -, 2, -, 4, -, 1 with idle gaps between packets.
- Wormhole lock: input E sends a 4-flit packet to N while input S requests N from cycle t+1.
  - S_N=0 for 4 transfer cycles; S gets no pop until E's tail has passed.
  - Then S_N=3 after one idle cycle.
- Back-pressure: locked E→W with out_ready[1]=0 for 3 cycles → S_W=0 held, pop[0]=0; flits resume in order when ready returns.
- Reset mid-packet: reset asserted during flit 2 of 4 → next cycle all selects 3'b111, pop=0, rr_ptr=0; a fresh request arbitrates normally afterwards.
